// File: rtl/main_memory_burst_if.sv
// Request/response bundle between the cache controller (master) and the burst memory (slave).
// Carries the valid/ready request, block write data, status and the read block.
interface main_memory_burst_if #(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 10,
  parameter int WORDS_PER_BLOCK = 4
);
  logic                              req_valid;
  logic                              req_ready;
  logic                              req_write;
  logic                              req_single;
  logic [ADDR_W-1:0]                 req_addr;
  logic [DATA_W*WORDS_PER_BLOCK-1:0] wr_data;
  logic                              busy;
  logic                              done;
  logic [DATA_W*WORDS_PER_BLOCK-1:0] rd_data;

  modport master (
    output req_valid, req_write, req_single, req_addr, wr_data,
    input  req_ready, busy, done, rd_data
  );

  modport slave (
    input  req_valid, req_write, req_single, req_addr, wr_data,
    output req_ready, busy, done, rd_data
  );
endinterface

// File: rtl/main_memory_burst.sv
// Burst backing store: block refill/write-back and single-word write, ACCESS_LATENCY wait then one beat per cycle,
// done pulses on the last beat; no queueing, req_ready is low for the whole operation so requesters must hold req_valid.
module main_memory_burst #(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 10,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int ACCESS_LATENCY  = 2
) (
  input logic                clk,
  input logic                rst,
  main_memory_burst_if.slave bus
);
  localparam int MAX_CNT = (ACCESS_LATENCY > WORDS_PER_BLOCK) ? ACCESS_LATENCY : WORDS_PER_BLOCK;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int BLK_W   = DATA_W * WORDS_PER_BLOCK;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_XFER} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    beat_q, beat_d;
  logic                write_q, write_d;
  logic                single_q, single_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [BLK_W-1:0]    wbuf_q, wbuf_d;
  logic [BLK_W-1:0]    rd_data_q, rd_data_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   mem_q [2**ADDR_W];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;

  logic                accept;
  logic                last_beat;
  logic [ADDR_W-1:0]   beat_addr;
  int                  lane;

  assign accept    = (state_q == ST_IDLE) && bus.req_valid;
  assign last_beat = single_q || (beat_q == CNT_W'(WORDS_PER_BLOCK - 1));
  // Block bases have their offset bits cleared, so this add never carries out of the block.
  assign beat_addr = base_q + ADDR_W'(beat_q);
  assign lane      = int'(beat_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.req_valid) state_d = (ACCESS_LATENCY == 0) ? ST_XFER : ST_WAIT;
      ST_WAIT: if (cnt_q == CNT_W'(ACCESS_LATENCY - 1)) state_d = ST_XFER;
      ST_XFER: if (last_beat) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == ST_IDLE);
    bus.busy      = (state_q != ST_IDLE);
    bus.done      = done_q;
    bus.rd_data   = rd_data_q;

    cnt_d     = cnt_q;
    beat_d    = beat_q;
    write_d   = write_q;
    single_d  = single_q;
    base_d    = base_q;
    wbuf_d    = wbuf_q;
    rd_data_d = rd_data_q;
    done_d    = 1'b0;
    // Gated by rst so an aborted burst stops writing on the reset edge itself.
    mem_we    = (state_q == ST_XFER) && write_q && !rst;
    mem_addr  = beat_addr;
    mem_wdata = wbuf_q[lane*DATA_W +: DATA_W];

    if (accept) begin
      write_d  = bus.req_write;
      single_d = bus.req_write && bus.req_single;
      base_d   = (bus.req_write && bus.req_single) ? bus.req_addr
                                                   : (bus.req_addr & ~ADDR_W'(WORDS_PER_BLOCK - 1));
      wbuf_d   = bus.wr_data;
      cnt_d    = '0;
      beat_d   = '0;
    end

    if (state_q == ST_WAIT) cnt_d = cnt_q + 1'b1;

    if (state_q == ST_XFER) begin
      beat_d = last_beat ? '0 : beat_q + 1'b1;
      done_d = last_beat;
      if (!write_q) rd_data_d[lane*DATA_W +: DATA_W] = mem_q[beat_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      beat_q    <= '0;
      write_q   <= 1'b0;
      single_q  <= 1'b0;
      base_q    <= '0;
      wbuf_q    <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
      write_q   <= write_d;
      single_q  <= single_d;
      base_q    <= base_d;
      wbuf_q    <= wbuf_d;
      rd_data_q <= rd_data_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
  end
endmodule

// File: tb/tb_main_memory_burst.sv
// Directed bench: default instance (latency 2, 4-word blocks) and a latency-0, 1-word instance.
module tb_main_memory_burst;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  main_memory_burst_if #(.DATA_W(32), .ADDR_W(10), .WORDS_PER_BLOCK(4)) ifa ();
  main_memory_burst_if #(.DATA_W(32), .ADDR_W(10), .WORDS_PER_BLOCK(1)) ifb ();

  main_memory_burst #(.DATA_W(32), .ADDR_W(10), .WORDS_PER_BLOCK(4), .ACCESS_LATENCY(2)) ua (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  main_memory_burst #(.DATA_W(32), .ADDR_W(10), .WORDS_PER_BLOCK(1), .ACCESS_LATENCY(0)) ub (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pres_a(input logic w, input logic s, input logic [9:0] a, input logic [127:0] d);
    ifa.req_valid  = 1'b1;
    ifa.req_write  = w;
    ifa.req_single = s;
    ifa.req_addr   = a;
    ifa.wr_data    = d;
  endtask

  task automatic pres_b(input logic w, input logic s, input logic [9:0] a, input logic [31:0] d);
    ifb.req_valid  = 1'b1;
    ifb.req_write  = w;
    ifb.req_single = s;
    ifb.req_addr   = a;
    ifb.wr_data    = d;
  endtask

  // Edges from accept until done is seen high; -1 if it never arrives.
  task automatic wait_a(output int n, output int rdy_lo);
    n = 0;
    rdy_lo = 0;
    while (!ifa.done && n < 40) begin
      if (!ifa.req_ready) rdy_lo++;
      step();
      n++;
    end
    if (!ifa.done) n = -1;
  endtask

  task automatic wait_b(output int n);
    n = 0;
    while (!ifb.done && n < 40) begin
      step();
      n++;
    end
    if (!ifb.done) n = -1;
  endtask

  task automatic req_a(input logic w, input logic s, input logic [9:0] a, input logic [127:0] d,
                       output int n, output int rdy_lo);
    pres_a(w, s, a, d);
    step();
    ifa.req_valid = 1'b0;
    wait_a(n, rdy_lo);
  endtask

  task automatic req_b(input logic w, input logic s, input logic [9:0] a, input logic [31:0] d,
                       output int n);
    pres_b(w, s, a, d);
    step();
    ifb.req_valid = 1'b0;
    wait_b(n);
  endtask

  initial begin
    int n;
    int rl;
    int extra;
    logic [127:0] blk_a;
    logic [127:0] blk_a2;

    blk_a  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    blk_a2 = {32'hA3, 32'hDEADBEEF, 32'hA1, 32'hA0};
    ifa.req_valid = 1'b0; ifa.req_write = 1'b0; ifa.req_single = 1'b0; ifa.req_addr = '0; ifa.wr_data = '0;
    ifb.req_valid = 1'b0; ifb.req_write = 1'b0; ifb.req_single = 1'b0; ifb.req_addr = '0; ifb.wr_data = '0;

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", ifa.busy, 0);
    chk("rst_done", ifa.done, 0);
    chk("rst_ready", ifa.req_ready, 1);
    chk("rst_rd_data", ifa.rd_data, 0);
    chk("rst_b_ready", ifb.req_ready, 1);

    req_a(1'b1, 1'b0, 10'h013, blk_a, n, rl);
    chk("blkwr_latency", n, 6);
    chk("blkwr_ready_low", rl, 6);
    chk("blkwr_done_busy", ifa.busy, 0);
    chk("blkwr_done_ready", ifa.req_ready, 1);
    step();
    chk("blkwr_done_pulse", ifa.done, 0);

    req_a(1'b0, 1'b0, 10'h010, '0, n, rl);
    chk("blkrd_latency", n, 6);
    chk("blkrd_data", ifa.rd_data, blk_a);

    req_a(1'b1, 1'b1, 10'h012, {32'h55, 32'h55, 32'h55, 32'hDEADBEEF}, n, rl);
    chk("single_latency", n, 3);
    chk("single_ready_low", rl, 3);
    chk("single_rd_untouched", ifa.rd_data, blk_a);

    req_a(1'b0, 1'b1, 10'h011, '0, n, rl);
    chk("rd_single_flag_latency", n, 6);
    chk("raw_data", ifa.rd_data, blk_a2);

    req_a(1'b1, 1'b0, 10'h030, {32'h33, 32'h32, 32'h31, 32'h30}, n, rl);
    chk("blkwr30_latency", n, 6);

    // Second request presented during the first done cycle.
    pres_a(1'b0, 1'b0, 10'h010, '0);
    step();
    ifa.req_valid = 1'b0;
    wait_a(n, rl);
    chk("b2b_first_latency", n, 6);
    chk("b2b_first_data", ifa.rd_data, blk_a2);
    pres_a(1'b0, 1'b0, 10'h030, '0);
    step();
    ifa.req_valid = 1'b0;
    chk("b2b_done_drop", ifa.done, 0);
    chk("b2b_accepted", ifa.busy, 1);
    wait_a(n, rl);
    chk("b2b_second_latency", n, 6);
    chk("b2b_second_data", ifa.rd_data, {32'h33, 32'h32, 32'h31, 32'h30});
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ifa.done) extra++;
    end
    chk("b2b_extra_done", extra, 0);

    req_a(1'b1, 1'b0, 10'h020, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, n, rl);
    chk("blkwr20_latency", n, 6);
    step();

    // Reset on the edge that would write beat 2: beats 0 and 1 land, 2 and 3 do not.
    pres_a(1'b1, 1'b0, 10'h020, {32'd4, 32'd3, 32'd2, 32'd1});
    step();
    ifa.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", ifa.busy, 0);
    chk("abort_done", ifa.done, 0);
    chk("abort_rd_cleared", ifa.rd_data, 0);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ifa.done) extra++;
    end
    chk("abort_no_done", extra, 0);
    req_a(1'b0, 1'b0, 10'h020, '0, n, rl);
    chk("abort_rd_latency", n, 6);
    chk("abort_partial", ifa.rd_data, {32'hB3, 32'hB2, 32'd2, 32'd1});

    req_b(1'b1, 1'b1, 10'h005, 32'hCAFE0001, n);
    chk("b_single_latency", n, 1);
    req_b(1'b1, 1'b0, 10'h007, 32'h77770007, n);
    chk("b_blkwr_latency", n, 1);
    req_b(1'b0, 1'b0, 10'h005, 32'h0, n);
    chk("b_rd_latency", n, 1);
    chk("b_rd_data", ifb.rd_data, 32'hCAFE0001);

    // A write presented while busy must be ignored.
    pres_b(1'b0, 1'b0, 10'h007, 32'h0);
    step();
    chk("b_busy", ifb.busy, 1);
    pres_b(1'b1, 1'b1, 10'h007, 32'h0BAD0BAD);
    step();
    ifb.req_valid = 1'b0;
    chk("b_done", ifb.done, 1);
    chk("b_rd7_data", ifb.rd_data, 32'h77770007);
    step();
    chk("b_done_pulse", ifb.done, 0);
    req_b(1'b0, 1'b0, 10'h007, 32'h0, n);
    chk("b_ignored_latency", n, 1);
    chk("b_ignored_write", ifb.rd_data, 32'h77770007);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
